// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/memory line-port arbiter.
// Arbiter FSM states, grant source tags and perf counter width.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

    localparam int PERF_W = 32;

endpackage

// File: rtl/cache_mem_arbiter_perf.sv
// arb_perf_cnt: grant and conflict event counters for the arbiter.
// Ports: clk, rst_n, grant_i/grant_d/conflict in; perf_* 32-bit out.
`ifdef CACHE_ARB_PERF_EN
module arb_perf_cnt
    import cache_mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              grant_i,
    input  logic              grant_d,
    input  logic              conflict,
    output logic [PERF_W-1:0] perf_i_grants,
    output logic [PERF_W-1:0] perf_d_grants,
    output logic [PERF_W-1:0] perf_conflict_cycles
);

    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_i_grants        <= '0;
            perf_d_grants        <= '0;
            perf_conflict_cycles <= '0;
        end else begin
            if (grant_i)
                perf_i_grants <= perf_i_grants + 1'b1;
            if (grant_d)
                perf_d_grants <= perf_d_grants + 1'b1;
            if (conflict)
                perf_conflict_cycles <= perf_conflict_cycles + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/cache_mem_arbiter.sv
// Shares one pmem line port between I-cache and D-cache miss paths.
// D has priority; after STARVE_LIMIT D grants with I waiting, I is forced.
// Ports: i_pmem_* / d_pmem_* cache side, pmem_* adaptor side, perf_* counters.
// Optional: CACHE_ARB_PERF_EN enables perf counters (else perf_* tied to 0).
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int LINE_W       = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [PERF_W-1:0] perf_i_grants,
    output logic [PERF_W-1:0] perf_d_grants,
    output logic [PERF_W-1:0] perf_conflict_cycles
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t        state;
    logic              op_write;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [CNT_W-1:0]  starve_cnt;

    logic     d_req;
    logic     force_i;
    logic     grant_d;
    logic     grant_i;
    logic     busy_i;
    logic     busy_d;
    arb_src_t grant_src;

    always_comb begin
        d_req     = d_pmem_read | d_pmem_write;
        force_i   = i_pmem_read && (starve_cnt == LIMIT);
        grant_d   = (state == IDLE) && d_req && !force_i;
        grant_i   = (state == IDLE) && i_pmem_read && !grant_d;
        grant_src = grant_d ? SRC_D : SRC_I;
        busy_i    = (state == I_BUSY);
        busy_d    = (state == D_BUSY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_write   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            starve_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_d || grant_i) begin
                        state  <= grant_d ? D_BUSY : I_BUSY;
                        addr_q <= (grant_src == SRC_D) ?
                                  d_pmem_address : i_pmem_address;
                        // Write wins when a cache raises both strobes.
                        op_write <= grant_d && d_pmem_write;
                        if (grant_d)
                            wdata_q <= d_pmem_wdata;
                        // Only D grants that bypass a waiting I count
                        // toward starvation; anything else resets it.
                        if (grant_d && i_pmem_read) begin
                            if (starve_cnt != LIMIT)
                                starve_cnt <= starve_cnt + 1'b1;
                        end else begin
                            starve_cnt <= '0;
                        end
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (pmem_resp)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes come purely from registered state so reset drops them
    // asynchronously and requests never reach the adaptor combinationally.
    always_comb begin
        pmem_read    = busy_i | (busy_d & ~op_write);
        pmem_write   = busy_d & op_write;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        i_pmem_resp  = busy_i & pmem_resp;
        d_pmem_resp  = busy_d & pmem_resp;
        i_pmem_rdata = i_pmem_resp ? pmem_rdata : '0;
        d_pmem_rdata = d_pmem_resp ? pmem_rdata : '0;
    end

`ifdef CACHE_ARB_PERF_EN
    logic conflict;

    assign conflict = (busy_i & d_req) | (busy_d & i_pmem_read);

    arb_perf_cnt u_perf (
        .clk                  (clk),
        .rst_n                (rst_n),
        .grant_i              (grant_i),
        .grant_d              (grant_d),
        .conflict             (conflict),
        .perf_i_grants        (perf_i_grants),
        .perf_d_grants        (perf_d_grants),
        .perf_conflict_cycles (perf_conflict_cycles)
    );
`else
    assign perf_i_grants        = '0;
    assign perf_d_grants        = '0;
    assign perf_conflict_cycles = '0;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed testbench for cache_mem_arbiter.
// Bench drives requests and plays the adaptor; checks at negedge.
module tb_cache_mem_arbiter;

`ifdef CACHE_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  perf_i_grants;
    logic [31:0]  perf_d_grants;
    logic [31:0]  perf_conflict_cycles;

    int tests = 0;
    int fails = 0;

    logic [255:0] line_a;
    logic [255:0] line_b;
    logic [255:0] line_c;
    logic [255:0] wb_line;

    cache_mem_arbiter dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_pmem_read          (i_pmem_read),
        .i_pmem_address       (i_pmem_address),
        .i_pmem_rdata         (i_pmem_rdata),
        .i_pmem_resp          (i_pmem_resp),
        .d_pmem_read          (d_pmem_read),
        .d_pmem_write         (d_pmem_write),
        .d_pmem_address       (d_pmem_address),
        .d_pmem_wdata         (d_pmem_wdata),
        .d_pmem_rdata         (d_pmem_rdata),
        .d_pmem_resp          (d_pmem_resp),
        .pmem_read            (pmem_read),
        .pmem_write           (pmem_write),
        .pmem_address         (pmem_address),
        .pmem_wdata           (pmem_wdata),
        .pmem_rdata           (pmem_rdata),
        .pmem_resp            (pmem_resp),
        .perf_i_grants        (perf_i_grants),
        .perf_d_grants        (perf_d_grants),
        .perf_conflict_cycles (perf_conflict_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic test_reset();
        mid();
        tests++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            fails++;
            $display("FAIL reset_strobes got %b exp 00",
                     {pmem_read, pmem_write});
        end
        tests++;
        if (pmem_address !== 32'h0 || pmem_wdata !== '0) begin
            fails++;
            $display("FAIL reset_addr_wdata got %h/%h exp 0",
                     pmem_address, pmem_wdata[31:0]);
        end
        tests++;
        if ({i_pmem_resp, d_pmem_resp} !== 2'b00 ||
            i_pmem_rdata !== '0 || d_pmem_rdata !== '0) begin
            fails++;
            $display("FAIL reset_resp got %b exp 00",
                     {i_pmem_resp, d_pmem_resp});
        end
        tests++;
        if (perf_i_grants !== 0 || perf_d_grants !== 0 ||
            perf_conflict_cycles !== 0) begin
            fails++;
            $display("FAIL reset_perf got %0d/%0d/%0d exp 0",
                     perf_i_grants, perf_d_grants,
                     perf_conflict_cycles);
        end
    endtask

    task automatic test_i_read();
        tick();
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_1000;
        mid();
        tests++;
        if (pmem_read !== 1'b0) begin
            fails++;
            $display("FAIL iread_latency got %b exp 0", pmem_read);
        end
        tick();
        mid();
        tests++;
        if ({pmem_read, pmem_write} !== 2'b10 ||
            pmem_address !== 32'h0000_1000) begin
            fails++;
            $display("FAIL iread_strobe got %b addr %h exp 10 addr 1000",
                     {pmem_read, pmem_write}, pmem_address);
        end
        repeat (3) tick();
        pmem_resp  = 1'b1;
        pmem_rdata = line_a;
        mid();
        tests++;
        if (i_pmem_resp !== 1'b1 || i_pmem_rdata !== line_a) begin
            fails++;
            $display("FAIL iread_resp got %b %h exp 1 %h",
                     i_pmem_resp, i_pmem_rdata[31:0], line_a[31:0]);
        end
        tests++;
        if (d_pmem_resp !== 1'b0 || d_pmem_rdata !== '0) begin
            fails++;
            $display("FAIL iread_dside got %b %h exp 0 0",
                     d_pmem_resp, d_pmem_rdata[31:0]);
        end
        tick();
        pmem_resp   = 1'b0;
        pmem_rdata  = '0;
        i_pmem_read = 1'b0;
        mid();
        tests++;
        if ({pmem_read, i_pmem_resp} !== 2'b00) begin
            fails++;
            $display("FAIL iread_done got %b exp 00",
                     {pmem_read, i_pmem_resp});
        end
    endtask

    task automatic test_conflict();
        tick();
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h100;
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h200;
        tick();
        mid();
        tests++;
        if (pmem_address !== 32'h200 || pmem_read !== 1'b1) begin
            fails++;
            $display("FAIL conflict_dfirst got %h %b exp 200 1",
                     pmem_address, pmem_read);
        end
        tick();
        pmem_resp  = 1'b1;
        pmem_rdata = line_b;
        mid();
        tests++;
        if ({i_pmem_resp, d_pmem_resp} !== 2'b01 ||
            d_pmem_rdata !== line_b || i_pmem_rdata !== '0) begin
            fails++;
            $display("FAIL conflict_dresp got %b %h exp 01 %h",
                     {i_pmem_resp, d_pmem_resp},
                     d_pmem_rdata[31:0], line_b[31:0]);
        end
        tick();
        pmem_resp   = 1'b0;
        pmem_rdata  = '0;
        d_pmem_read = 1'b0;
        mid();
        tests++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            fails++;
            $display("FAIL conflict_gap got %b exp 00",
                     {pmem_read, pmem_write});
        end
        tick();
        mid();
        tests++;
        if (pmem_address !== 32'h100 || pmem_read !== 1'b1) begin
            fails++;
            $display("FAIL conflict_isecond got %h %b exp 100 1",
                     pmem_address, pmem_read);
        end
        tick();
        pmem_resp  = 1'b1;
        pmem_rdata = line_c;
        mid();
        tests++;
        if ({i_pmem_resp, d_pmem_resp} !== 2'b10 ||
            i_pmem_rdata !== line_c) begin
            fails++;
            $display("FAIL conflict_iresp got %b %h exp 10 %h",
                     {i_pmem_resp, d_pmem_resp},
                     i_pmem_rdata[31:0], line_c[31:0]);
        end
        tick();
        pmem_resp   = 1'b0;
        pmem_rdata  = '0;
        i_pmem_read = 1'b0;
        mid();
        // Grants so far: I (i_read test), D then I here.
        // D_BUSY lasted two edges with I waiting.
        tests++;
        if (perf_i_grants !== (PERF ? 32'd2 : 32'd0) ||
            perf_d_grants !== (PERF ? 32'd1 : 32'd0)) begin
            fails++;
            $display("FAIL perf_grants got i%0d d%0d exp i%0d d%0d",
                     perf_i_grants, perf_d_grants,
                     PERF ? 2 : 0, PERF ? 1 : 0);
        end
        tests++;
        if (perf_conflict_cycles !== (PERF ? 32'd2 : 32'd0)) begin
            fails++;
            $display("FAIL perf_conflict got %0d exp %0d",
                     perf_conflict_cycles, PERF ? 2 : 0);
        end
    endtask

    task automatic test_writeback();
        tick();
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h300;
        d_pmem_wdata   = wb_line;
        tick();
        mid();
        tests++;
        if ({pmem_read, pmem_write} !== 2'b01) begin
            fails++;
            $display("FAIL wb_strobe got %b exp 01",
                     {pmem_read, pmem_write});
        end
        tests++;
        if (pmem_wdata !== wb_line || pmem_address !== 32'h300) begin
            fails++;
            $display("FAIL wb_data got %h %h exp %h 300",
                     pmem_wdata[31:0], pmem_address, wb_line[31:0]);
        end
        tick();
        pmem_resp = 1'b1;
        mid();
        tests++;
        if ({i_pmem_resp, d_pmem_resp} !== 2'b01) begin
            fails++;
            $display("FAIL wb_resp got %b exp 01",
                     {i_pmem_resp, d_pmem_resp});
        end
        tick();
        pmem_resp    = 1'b0;
        d_pmem_write = 1'b0;
        d_pmem_wdata = '0;
        mid();
        tests++;
        if (pmem_write !== 1'b0) begin
            fails++;
            $display("FAIL wb_done got %b exp 0", pmem_write);
        end
    endtask

    task automatic test_starvation();
        logic [5:0]  is_i;
        logic [31:0] exp_addr;
        is_i = 6'b010000;
        tick();
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h400;
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h500;
        for (int k = 0; k < 6; k++) begin
            tick();
            mid();
            exp_addr = is_i[k] ? 32'h400 : d_pmem_address;
            tests++;
            if (pmem_address !== exp_addr) begin
                fails++;
                $display("FAIL starve_grant%0d got %h exp %h",
                         k, pmem_address, exp_addr);
            end
            tick();
            pmem_resp  = 1'b1;
            pmem_rdata = line_a;
            mid();
            tests++;
            if ({i_pmem_resp, d_pmem_resp} !==
                (is_i[k] ? 2'b10 : 2'b01)) begin
                fails++;
                $display("FAIL starve_resp%0d got %b exp %b", k,
                         {i_pmem_resp, d_pmem_resp},
                         is_i[k] ? 2'b10 : 2'b01);
            end
            tick();
            pmem_resp  = 1'b0;
            pmem_rdata = '0;
            if (!is_i[k])
                d_pmem_address = d_pmem_address + 32'h20;
        end
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
    endtask

    task automatic test_spurious();
        tick();
        pmem_resp  = 1'b1;
        pmem_rdata = line_b;
        mid();
        tests++;
        if ({i_pmem_resp, d_pmem_resp} !== 2'b00 ||
            i_pmem_rdata !== '0 || d_pmem_rdata !== '0) begin
            fails++;
            $display("FAIL spurious_resp got %b exp 00",
                     {i_pmem_resp, d_pmem_resp});
        end
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        mid();
        tests++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            fails++;
            $display("FAIL spurious_idle got %b exp 00",
                     {pmem_read, pmem_write});
        end
    endtask

    task automatic test_reset_mid();
        tick();
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h600;
        tick();
        mid();
        tests++;
        if (pmem_read !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_busy got %b exp 1", pmem_read);
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({pmem_read, pmem_write} !== 2'b00 ||
            pmem_address !== 32'h0) begin
            fails++;
            $display("FAIL rstmid_async got %b %h exp 00 0",
                     {pmem_read, pmem_write}, pmem_address);
        end
        pmem_resp = 1'b1;
        #1;
        tests++;
        if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin
            fails++;
            $display("FAIL rstmid_noresp got %b exp 00",
                     {i_pmem_resp, d_pmem_resp});
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        mid();
        tests++;
        if (pmem_read !== 1'b1 || pmem_address !== 32'h600) begin
            fails++;
            $display("FAIL rstmid_regrant got %b %h exp 1 600",
                     pmem_read, pmem_address);
        end
        tests++;
        if (perf_d_grants !== (PERF ? 32'd1 : 32'd0)) begin
            fails++;
            $display("FAIL rstmid_perf got %0d exp %0d",
                     perf_d_grants, PERF ? 1 : 0);
        end
        tick();
        pmem_resp  = 1'b1;
        pmem_rdata = line_c;
        mid();
        tests++;
        if (d_pmem_resp !== 1'b1 || d_pmem_rdata !== line_c) begin
            fails++;
            $display("FAIL rstmid_resp got %b %h exp 1 %h",
                     d_pmem_resp, d_pmem_rdata[31:0], line_c[31:0]);
        end
        tick();
        pmem_resp   = 1'b0;
        pmem_rdata  = '0;
        d_pmem_read = 1'b0;
    endtask

    initial begin
        line_a         = {8{32'hA5A5_0001}};
        line_b         = {8{32'h1234_5678}};
        line_c         = {8{32'h0F0F_C3C3}};
        wb_line        = {8{32'hDEADBEEF}};
        rst_n          = 1'b0;
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        pmem_rdata     = '0;
        pmem_resp      = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        tick();
        rst_n = 1'b1;
        test_i_read();
        test_conflict();
        test_writeback();
        test_starvation();
        test_spurious();
        test_reset_mid();
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
